// File: rtl/low_fre_period_meter_pkg.sv
// Package low_fre_pkg: shared encodings for the low-frequency period meter.
//   ST_IDLE / ST_ARM / ST_MEAS   FSM state encoding
//   MODE_PERIOD / MODE_HIGH      values of the mode input
package low_fre_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic MODE_PERIOD = 1'b0;  // rise -> rise
  localparam logic MODE_HIGH   = 1'b1;  // rise -> fall

endpackage

// File: rtl/low_fre_period_meter_if.sv
// Interface bundling the control inputs and result outputs of the period meter.
//   en, mode, f_in_gate                         : driven by the controller (master)
//   result, result_valid, overflow, timeout, busy : driven by the meter (slave)
interface low_fre_period_meter_if #(
  parameter int unsigned CNT_W = 32
);
  logic             en;
  logic             mode;
  logic             f_in_gate;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic             timeout;
  logic             busy;

  modport master (
    output en, mode, f_in_gate,
    input  result, result_valid, overflow, timeout, busy
  );

  modport slave (
    input  en, mode, f_in_gate,
    output result, result_valid, overflow, timeout, busy
  );
endinterface

// File: rtl/low_fre_period_meter_edge_sync.sv
// edge_sync_detect: synchronises an asynchronous level into sys_count_clk and
// flags its edges for one cycle.
//   sys_count_clk  in  clock
//   rst            in  synchronous reset, active-high
//   d_async        in  asynchronous input
//   rise / fall    out single-cycle edge flags (combinational from the last two flops)
module edge_sync_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_count_clk,
  input  logic rst,
  input  logic d_async,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge sys_count_clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    fall = ~sync_q[SYNC_STAGES-1] & dly_q;
  end

endmodule

// File: rtl/low_fre_period_meter.sv
// low_fre_period_meter: counts sys_count_clk cycles between edges of f_in_gate
// (full period or high time), averages 2^AVG_LOG2 samples, saturates on
// overflow and reports a missing input through a timeout result.
//   sys_count_clk  in  reference/count clock
//   rst            in  synchronous reset, active-high
//   bus (slave)        en, mode, f_in_gate in; result, result_valid,
//                      overflow, timeout, busy out
module low_fre_period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned AVG_LOG2    = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 50_000_000
) (
  input  logic                  sys_count_clk,
  input  logic                  rst,
  low_fre_period_meter_if.slave bus
);
  import low_fre_pkg::*;

  localparam int unsigned      ACC_W    = CNT_W + AVG_LOG2;
  localparam int unsigned      SMP_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [SMP_W-1:0] smp_cnt;
  logic             sat_seen;
  logic [31:0]      tmo;

  logic [CNT_W-1:0] result_q;
  logic             valid_q;
  logic             ovf_q;
  logic             tmo_flag_q;

  logic             rise;
  logic             fall;
  logic             close_edge;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] avg_res;
  logic             sat_next;
  logic [CNT_W-1:0] cnt_inc;

  edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sys_count_clk (sys_count_clk),
    .rst           (rst),
    .d_async       (bus.f_in_gate),
    .rise          (rise),
    .fall          (fall)
  );

  // Result is formed from acc plus the sample closing this cycle, so it is
  // ready in the same register update that folds that sample into acc.
  always_comb begin
    close_edge = (mode_q == MODE_PERIOD) ? rise : fall;
    acc_sum    = acc + ACC_W'(cnt);
    avg_res    = CNT_W'(acc_sum >> AVG_LOG2);
    sat_next   = sat_seen | (cnt == CNT_MAX);
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge sys_count_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_PERIOD;
      cnt        <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      sat_seen   <= 1'b0;
      tmo        <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.en) begin
        // Abort: discard partial data, keep the last reported result.
        state    <= ST_IDLE;
        cnt      <= '0;
        acc      <= '0;
        smp_cnt  <= '0;
        sat_seen <= 1'b0;
        tmo      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            mode_q <= bus.mode;
            tmo    <= '0;
            state  <= ST_ARM;
          end
          ST_ARM, ST_MEAS: begin
            if (state == ST_ARM && rise) begin
              cnt   <= CNT_W'(1);
              tmo   <= '0;
              state <= ST_MEAS;
            end else if (state == ST_MEAS && close_edge) begin
              tmo <= '0;
              if (smp_cnt == SMP_LAST) begin
                result_q   <= avg_res;
                ovf_q      <= sat_next;
                tmo_flag_q <= 1'b0;
                valid_q    <= 1'b1;
                acc        <= '0;
                smp_cnt    <= '0;
                sat_seen   <= 1'b0;
              end else begin
                acc      <= acc_sum;
                smp_cnt  <= smp_cnt + SMP_W'(1);
                sat_seen <= sat_next;
              end
              // In period mode the closing rise also opens the next period.
              if (mode_q == MODE_PERIOD) cnt <= CNT_W'(1);
              else                       state <= ST_ARM;
            end else if (tmo == TMO_LAST) begin
              result_q   <= '0;
              ovf_q      <= 1'b0;
              tmo_flag_q <= 1'b1;
              valid_q    <= 1'b1;
              acc        <= '0;
              smp_cnt    <= '0;
              sat_seen   <= 1'b0;
              tmo        <= '0;
              state      <= ST_ARM;
            end else begin
              if (state == ST_MEAS) cnt <= cnt_inc;
              tmo <= rise ? '0 : tmo + 32'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.timeout      = tmo_flag_q;
  assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_low_fre_period_meter.sv
// Directed self-checking bench for low_fre_period_meter.
//   u0: CNT_W=32, AVG_LOG2=0, TIMEOUT=1000 (period, high time, abort, timeout, reset)
//   u1: CNT_W=32, AVG_LOG2=2 (averaging)
//   u2: CNT_W=8,  AVG_LOG2=0 (saturation)
module tb_low_fre_period_meter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  low_fre_period_meter_if #(.CNT_W(32)) b0 ();
  low_fre_period_meter_if #(.CNT_W(32)) b1 ();
  low_fre_period_meter_if #(.CNT_W(8))  b2 ();

  low_fre_period_meter #(.CNT_W(32), .AVG_LOG2(0), .SYNC_STAGES(2), .TIMEOUT(1000)) u0 (
    .sys_count_clk(clk), .rst(rst), .bus(b0));
  low_fre_period_meter #(.CNT_W(32), .AVG_LOG2(2), .SYNC_STAGES(2), .TIMEOUT(1000)) u1 (
    .sys_count_clk(clk), .rst(rst), .bus(b1));
  low_fre_period_meter #(.CNT_W(8), .AVG_LOG2(0), .SYNC_STAGES(2), .TIMEOUT(1000)) u2 (
    .sys_count_clk(clk), .rst(rst), .bus(b2));

  logic [2:0]  vld;
  logic [2:0]  ovf_w;
  logic [2:0]  tmo_w;
  logic [31:0] res_w [3];

  assign vld     = {b2.result_valid, b1.result_valid, b0.result_valid};
  assign ovf_w   = {b2.overflow, b1.overflow, b0.overflow};
  assign tmo_w   = {b2.timeout, b1.timeout, b0.timeout};
  assign res_w[0] = b0.result;
  assign res_w[1] = b1.result;
  assign res_w[2] = {24'd0, b2.result};

  // Valid-pulse monitor: count and capture the outputs of every strobe.
  int          vcnt [3] = '{0, 0, 0};
  int          vcyc [3] = '{0, 0, 0};
  logic [31:0] vres [3];
  logic        vovf [3];
  logic        vtmo [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        vcnt[i] = vcnt[i] + 1;
        vcyc[i] = cyc;
        vres[i] = res_w[i];
        vovf[i] = ovf_w[i];
        vtmo[i] = tmo_w[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int s;
  int r;
  int e;
  int n;
  int per [8] = '{98, 100, 102, 100, 96, 100, 104, 108};

  initial begin
    rst = 1'b1;
    b0.en = 1'b0; b0.mode = 1'b0; b0.f_in_gate = 1'b0;
    b1.en = 1'b0; b1.mode = 1'b0; b1.f_in_gate = 1'b0;
    b2.en = 1'b0; b2.mode = 1'b0; b2.f_in_gate = 1'b0;
    tick(3);

    // Reset state
    chk("rst_result",   res_w[0], 32'd0);
    chk("rst_valid",    32'(vld[0]), 32'd0);
    chk("rst_overflow", 32'(ovf_w[0]), 32'd0);
    chk("rst_timeout",  32'(tmo_w[0]), 32'd0);
    chk("rst_busy",     32'(b0.busy), 32'd0);
    chk("rst_busy_u2",  32'(b2.busy), 32'd0);
    rst = 1'b0;
    tick(1);

    // Full period, 100 clocks
    b0.mode = 1'b0; b0.en = 1'b1;
    tick(2);
    chk("t1_busy", 32'(b0.busy), 32'd1);
    s = vcnt[0];
    b0.f_in_gate = 1'b1; tick(50); b0.f_in_gate = 1'b0; tick(50);
    chk("t1_no_valid_on_arm", 32'(vcnt[0] - s), 32'd0);
    b0.f_in_gate = 1'b1; r = cyc; tick(10);
    chk("t1_first_valid", 32'(vcnt[0] - s), 32'd1);
    // Input changes in cycle r; the strobe occupies cycle r+3.
    chk("t1_latency", 32'(vcyc[0] - r), 32'd3);
    chk("t1_result", vres[0], 32'd100);
    chk("t1_overflow", 32'(vovf[0]), 32'd0);
    chk("t1_timeout", 32'(vtmo[0]), 32'd0);
    tick(40); b0.f_in_gate = 1'b0; tick(50);
    b0.f_in_gate = 1'b1; tick(50); b0.f_in_gate = 1'b0; tick(50);
    chk("t1_second_valid", 32'(vcnt[0] - s), 32'd2);
    chk("t1_result2", vres[0], 32'd100);

    // Abort mid-measurement: idle, result held, no strobes while idle
    s = vcnt[0];
    b0.en = 1'b0;
    tick(2);
    chk("t6_abort_busy", 32'(b0.busy), 32'd0);
    chk("t6_abort_hold", res_w[0], 32'd100);
    b0.mode = 1'b1;
    b0.f_in_gate = 1'b1; tick(30); b0.f_in_gate = 1'b0; tick(70);
    chk("t6_idle_no_valid", 32'(vcnt[0] - s), 32'd0);

    // High time 30 / low 70; mode change while armed is ignored
    b0.en = 1'b1;
    tick(2);
    b0.mode = 1'b0;
    s = vcnt[0];
    repeat (3) begin
      b0.f_in_gate = 1'b1; tick(30); b0.f_in_gate = 1'b0; tick(70);
    end
    chk("t3_valids", 32'(vcnt[0] - s), 32'd3);
    chk("t3_result", vres[0], 32'd30);
    chk("t3_overflow", 32'(vovf[0]), 32'd0);

    // Timeout with input held low
    b0.en = 1'b0;
    tick(2);
    b0.mode = 1'b0; b0.en = 1'b1; e = cyc;
    s = vcnt[0];
    n = 0;
    while (vcnt[0] == s && n < 1100) begin
      tick(1);
      n++;
    end
    chk("t4_valid_seen", 32'(vcnt[0] - s), 32'd1);
    // en sampled at edge e+1, tmo reaches 999 then fires on the next edge.
    chk("t4_valid_cycle", 32'(vcyc[0] - e), 32'd1001);
    chk("t4_result", vres[0], 32'd0);
    chk("t4_timeout", 32'(vtmo[0]), 32'd1);
    chk("t4_overflow", 32'(vovf[0]), 32'd0);
    b0.f_in_gate = 1'b1; tick(50); b0.f_in_gate = 1'b0; tick(50);
    b0.f_in_gate = 1'b1; tick(10);
    chk("t4_recover_valids", 32'(vcnt[0] - s), 32'd2);
    chk("t4_recover_result", vres[0], 32'd100);
    chk("t4_recover_timeout", 32'(vtmo[0]), 32'd0);

    // Reset mid-measurement
    tick(40); b0.f_in_gate = 1'b0; tick(20);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_result", res_w[0], 32'd0);
    chk("t6_rst_timeout", 32'(tmo_w[0]), 32'd0);
    chk("t6_rst_busy", 32'(b0.busy), 32'd0);
    chk("t6_rst_valid", 32'(vld[0]), 32'd0);
    s = vcnt[0];
    rst = 1'b0;
    tick(60);
    chk("t6_rearm_busy", 32'(b0.busy), 32'd1);
    chk("t6_no_stale_valid", 32'(vcnt[0] - s), 32'd0);
    b0.f_in_gate = 1'b1; tick(50); b0.f_in_gate = 1'b0; tick(50);
    chk("t6_arm_edge_only", 32'(vcnt[0] - s), 32'd0);
    b0.f_in_gate = 1'b1; tick(10);
    chk("t6_post_rst_valid", 32'(vcnt[0] - s), 32'd1);
    chk("t6_post_rst_result", vres[0], 32'd100);
    b0.en = 1'b0;
    b0.f_in_gate = 1'b0;

    // Averaging over 4: 98,100,102,100 -> 100; 96,100,104,108 -> 102
    b1.mode = 1'b0; b1.en = 1'b1;
    tick(2);
    s = vcnt[1];
    for (int i = 0; i < 8; i++) begin
      b1.f_in_gate = 1'b1; tick(10);
      if (i == 3) chk("t2_no_early_valid", 32'(vcnt[1] - s), 32'd0);
      if (i == 4) begin
        chk("t2_batch1_valids", 32'(vcnt[1] - s), 32'd1);
        chk("t2_batch1_result", vres[1], 32'd100);
        chk("t2_batch1_overflow", 32'(vovf[1]), 32'd0);
      end
      if (i == 7) chk("t2_batch2_pending", 32'(vcnt[1] - s), 32'd1);
      tick(per[i] / 2 - 10);
      b1.f_in_gate = 1'b0;
      tick(per[i] - per[i] / 2);
    end
    b1.f_in_gate = 1'b1; tick(10);
    chk("t2_batch2_valids", 32'(vcnt[1] - s), 32'd2);
    chk("t2_batch2_result", vres[1], 32'd102);
    b1.en = 1'b0;
    b1.f_in_gate = 1'b0;

    // 8-bit counter: 300 saturates, then 200 fits
    b2.mode = 1'b0; b2.en = 1'b1;
    tick(2);
    s = vcnt[2];
    b2.f_in_gate = 1'b1; tick(150); b2.f_in_gate = 1'b0; tick(150);
    b2.f_in_gate = 1'b1; tick(10);
    chk("t5_sat_valids", 32'(vcnt[2] - s), 32'd1);
    chk("t5_sat_result", vres[2], 32'd255);
    chk("t5_sat_overflow", 32'(vovf[2]), 32'd1);
    tick(90); b2.f_in_gate = 1'b0; tick(100);
    b2.f_in_gate = 1'b1; tick(10);
    chk("t5_fit_valids", 32'(vcnt[2] - s), 32'd2);
    chk("t5_fit_result", vres[2], 32'd200);
    chk("t5_fit_overflow", 32'(vovf[2]), 32'd0);
    b2.en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
